// File: rtl/warships_pkg.sv
// rtl/warships_pkg.sv - shared types and constants for the shot controller
package warships_pkg;

  localparam logic [7:0] COR_INVALID = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AIM      = 2'd1,
    REQ      = 2'd2,
    WAIT_RES = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } cor_t;

endpackage

// File: rtl/shot_ctrl_if.sv
// rtl/shot_ctrl_if.sv - shot request / result handshake towards the game logic
interface shot_ctrl_if;
  logic       shot_valid;
  logic [7:0] shot_cor;
  logic       shot_ready;
  logic       res_valid;
  logic       res_hit;

  modport master (
    output shot_valid, shot_cor,
    input  shot_ready, res_valid, res_hit
  );

  modport slave (
    input  shot_valid, shot_cor,
    output shot_ready, res_valid, res_hit
  );
endinterface

// File: rtl/shot_ctrl_history.sv
// rtl/shot_ctrl_history.sv - 256-cell fired-on bitmap, one-cycle clear, test and set
module shot_history
  import warships_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] rd_addr,
  output logic       rd_hit
);

  logic [255:0] bits_q, bits_d;

  // Clear beats write so a new game never inherits a same-cycle shot.
  always_comb begin
    bits_d = bits_q;
    if (clr) begin
      bits_d = '0;
    end else if (wr_en && (wr_addr != COR_INVALID)) begin
      bits_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign rd_hit = bits_q[rd_addr];

endmodule

// File: rtl/shot_ctrl.sv
// rtl/shot_ctrl.sv - turns one click on a fresh enemy cell into one shot request
module shot_ctrl
  import warships_pkg::*;
#(
  parameter int RES_TIMEOUT = 1_000_000,
  parameter int TMO_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  enemy_cor,
  input  logic        left,
  input  logic        start_btn,
  input  logic        my_turn,
  shot_ctrl_if.master shot_if,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        repeat_pulse,
  output logic        timeout_pulse,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_AIM      = AIM;
  localparam logic [1:0] ST_REQ      = REQ;
  localparam logic [1:0] ST_WAIT_RES = WAIT_RES;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RES_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             shot_valid_q, shot_valid_d;
  cor_t             shot_cor_q, shot_cor_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             repeat_q, repeat_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             left_q, start_q;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic click, new_game;
  logic hist_clr, hist_wr, hist_hit;

  assign click    = left & ~left_q;
  assign new_game = start_btn & ~start_q;

  shot_history u_history (
    .clk     (clk),
    .rst     (rst),
    .clr     (hist_clr),
    .wr_en   (hist_wr),
    .wr_addr (enemy_cor),
    .rd_addr (enemy_cor),
    .rd_hit  (hist_hit)
  );

  always_comb begin
    state_d      = state_q;
    shot_valid_d = shot_valid_q;
    shot_cor_d   = shot_cor_q;
    cnt_d        = cnt_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    repeat_d     = 1'b0;
    timeout_d    = 1'b0;
    hist_clr     = 1'b0;
    hist_wr      = 1'b0;

    if (new_game) begin
      hist_clr     = 1'b1;
      state_d      = ST_IDLE;
      shot_valid_d = 1'b0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (my_turn) state_d = ST_AIM;
        end
        ST_AIM: begin
          if (!my_turn) begin
            state_d = ST_IDLE;
          end else if (click && (enemy_cor != COR_INVALID)) begin
            if (hist_hit) begin
              repeat_d = 1'b1;
            end else begin
              shot_cor_d   = enemy_cor;
              hist_wr      = 1'b1;
              shot_valid_d = 1'b1;
              state_d      = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (shot_valid_q && shot_if.shot_ready) begin
            shot_valid_d = 1'b0;
            cnt_d        = '0;
            state_d      = ST_WAIT_RES;
          end
        end
        default: begin
          // A result arriving on the last allowed cycle still counts.
          if (shot_if.res_valid) begin
            hit_d   = shot_if.res_hit;
            miss_d  = ~shot_if.res_hit;
            state_d = ST_IDLE;
          end else if (cnt_q == TMO_LAST) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT_RES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shot_valid_q <= 1'b0;
      shot_cor_q   <= COR_INVALID;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      repeat_q     <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      left_q       <= 1'b0;
      start_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      shot_valid_q <= shot_valid_d;
      shot_cor_q   <= shot_cor_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      repeat_q     <= repeat_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      left_q       <= left;
      start_q      <= start_btn;
      cnt_q        <= cnt_d;
    end
  end

  assign shot_if.shot_valid = shot_valid_q;
  assign shot_if.shot_cor   = shot_cor_q;
  assign hit_pulse          = hit_q;
  assign miss_pulse         = miss_q;
  assign repeat_pulse       = repeat_q;
  assign timeout_pulse      = timeout_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_shot_ctrl.sv
// tb/tb_shot_ctrl.sv - directed and randomized checks of shot_ctrl against a transaction model
module tb_shot_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] enemy_cor;
  logic       left;
  logic       start_btn;
  logic       my_turn;
  logic       hit_pulse, miss_pulse, repeat_pulse, timeout_pulse, busy;

  int n_tests = 0;
  int n_fail  = 0;

  bit fired [256];

  shot_ctrl_if sif ();

  shot_ctrl #(.RES_TIMEOUT(16), .TMO_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .enemy_cor     (enemy_cor),
    .left          (left),
    .start_btn     (start_btn),
    .my_turn       (my_turn),
    .shot_if       (sif),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .repeat_pulse  (repeat_pulse),
    .timeout_pulse (timeout_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {hit_pulse, miss_pulse, repeat_pulse, timeout_pulse};
  endfunction

  task automatic click(input logic [7:0] c);
    enemy_cor = c;
    left = 1'b1;
    tick();
    left = 1'b0;
  endtask

  task automatic aim();
    my_turn = 1'b1;
    left = 1'b0;
    tick();
    tick();
  endtask

  task automatic handshake();
    sif.shot_ready = 1'b1;
    tick();
    sif.shot_ready = 1'b0;
  endtask

  task automatic result(input logic h);
    sif.res_valid = 1'b1;
    sif.res_hit   = h;
    tick();
    sif.res_valid = 1'b0;
    sif.res_hit   = 1'b0;
  endtask

  task automatic new_game();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
    foreach (fired[i]) fired[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] c;
    logic       h;
    int         d;

    rst = 1'b1; enemy_cor = 8'hFF; left = 1'b0; start_btn = 1'b0; my_turn = 1'b0;
    sif.shot_ready = 1'b0; sif.res_valid = 1'b0; sif.res_hit = 1'b0;
    repeat (3) tick();
    check("rst_valid", sif.shot_valid, 1'b0);
    check("rst_cor", sif.shot_cor, 8'hFF);
    check("rst_pulses", pulses(), 4'b0000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Basic shot with the button held for three cycles
    aim();
    enemy_cor = 8'h23; left = 1'b1;
    tick();
    check("basic_valid", sif.shot_valid, 1'b1);
    check("basic_cor", sif.shot_cor, 8'h23);
    check("basic_busy", busy, 1'b1);
    tick(); tick();
    left = 1'b0;
    check("basic_hold_cor", sif.shot_cor, 8'h23);
    handshake();
    check("basic_hs_valid", sif.shot_valid, 1'b0);
    check("basic_hs_busy", busy, 1'b1);
    result(1'b1);
    check("basic_hit", pulses(), 4'b1000);
    check("basic_idle_busy", busy, 1'b0);
    tick();
    check("basic_hit_width", pulses(), 4'b0000);

    // Repeat and off-board clicks
    aim();
    click(8'h23);
    check("repeat_pulse", pulses(), 4'b0010);
    check("repeat_novalid", sif.shot_valid, 1'b0);
    tick();
    check("repeat_width", pulses(), 4'b0000);
    tick();
    click(8'hFF);
    check("offboard_pulses", pulses(), 4'b0000);
    check("offboard_valid", sif.shot_valid, 1'b0);
    check("offboard_cor", sif.shot_cor, 8'h23);

    // Backpressure with cursor and button noise
    tick();
    click(8'h45);
    for (int k = 0; k < 10; k++) begin
      enemy_cor = 8'($urandom);
      left = 1'($urandom);
      tick();
      check("bp_valid", sif.shot_valid, 1'b1);
      check("bp_cor", sif.shot_cor, 8'h45);
    end
    left = 1'b0;
    handshake();
    check("bp_hs_valid", sif.shot_valid, 1'b0);
    result(1'b0);
    check("bp_miss", pulses(), 4'b0100);

    // Timeout after RES_TIMEOUT cycles in the result wait
    aim();
    click(8'h56);
    handshake();
    repeat (15) tick();
    check("tmo_not_yet", pulses(), 4'b0000);
    check("tmo_busy", busy, 1'b1);
    tick();
    check("tmo_pulse", pulses(), 4'b0001);
    check("tmo_busy_low", busy, 1'b0);
    tick();
    check("tmo_width", pulses(), 4'b0000);
    aim();
    click(8'h56);
    check("tmo_repeat", pulses(), 4'b0010);

    // Result on the final allowed cycle beats the timeout
    tick();
    click(8'h57);
    handshake();
    repeat (15) tick();
    result(1'b0);
    check("tmo_race", pulses(), 4'b0100);

    // New game while a request is pending
    aim();
    click(8'h10);
    check("ng_req", sif.shot_valid, 1'b1);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    check("ng_drop", sif.shot_valid, 1'b0);
    check("ng_busy", busy, 1'b0);
    aim();
    click(8'h10);
    check("ng_refire", sif.shot_valid, 1'b1);
    handshake();
    result(1'b1);
    check("ng_hit", pulses(), 4'b1000);
    aim();
    click(8'h23);
    check("ng_23_fresh", sif.shot_valid, 1'b1);
    handshake();
    result(1'b1);

    // Turn gating
    my_turn = 1'b0;
    tick(); tick();
    click(8'h30);
    check("turn_block", sif.shot_valid, 1'b0);
    check("turn_block_busy", busy, 1'b0);
    enemy_cor = 8'h30; left = 1'b1;
    tick();
    my_turn = 1'b1;
    repeat (3) tick();
    check("turn_no_edge", sif.shot_valid, 1'b0);
    left = 1'b0;
    tick();
    click(8'h30);
    check("turn_fire", sif.shot_valid, 1'b1);
    check("turn_cor", sif.shot_cor, 8'h30);
    handshake();
    result(1'b0);

    // Randomized shots against a fired-cell model
    new_game();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) new_game();
      if ($urandom_range(0, 19) == 0) c = 8'hFF;
      else c = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      aim();
      click(c);
      if (c == 8'hFF) begin
        check("rnd_off_valid", sif.shot_valid, 1'b0);
        check("rnd_off_pulses", pulses(), 4'b0000);
      end else if (fired[c]) begin
        check("rnd_rep_pulses", pulses(), 4'b0010);
        check("rnd_rep_valid", sif.shot_valid, 1'b0);
      end else begin
        fired[c] = 1'b1;
        check("rnd_valid", sif.shot_valid, 1'b1);
        check("rnd_cor", sif.shot_cor, c);
        d = $urandom_range(0, 3);
        repeat (d) tick();
        check("rnd_held", sif.shot_valid, 1'b1);
        handshake();
        d = $urandom_range(0, 5);
        repeat (d) tick();
        h = 1'($urandom);
        result(h);
        check("rnd_result", pulses(), h ? 4'b1000 : 4'b0100);
        tick();
        check("rnd_result_width", pulses(), 4'b0000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
